mm_link_ctrl: RTL



---
 rtl/mm_link_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mm_link_ctrl.sv
// mm_link_ctrl: UART-side framing, operand load and result streaming
// for the matrix-multiply accelerator.
module mm_link_ctrl #(
  parameter int         MAX_N    = 8,
  parameter int         RES_W    = 24,
  parameter logic [7:0] SYNC     = 8'hA5,
  parameter logic [7:0] ERR_CODE = 8'hEE,
  parameter int         TIMEOUT  = 100000,
  parameter int         AW       = $clog2(MAX_N*MAX_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data,
  output logic             mult_start,
  input  logic             mult_done,
  output logic [AW-1:0]    rd_addr,
  input  logic [RES_W-1:0] rd_data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic [2:0]       state,
  output logic [3:0]       matrix_size,
  output logic             done,
  output logic             err
);

  localparam int BYTES = RES_W / 8;
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int IW    = AW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SIZE    = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_B  = 3'd3,
    COMPUTE = 3'd4,
    SEND    = 3'd5,
    ERR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_ADDR,
    PH_LATCH,
    PH_TX
  } phase_t;

  state_t           st, nxt;
  phase_t           ph;
  logic [IW-1:0]    idx, limit, sq;
  logic [TW-1:0]    tcnt;
  logic [RES_W-1:0] shreg;
  logic [BW-1:0]    bcnt;
  logic             in_comp;
  logic             loading, tmo, size_ok;
  logic             idx_last, last_byte;

  assign state     = st;
  assign loading   = (st == SIZE) || (st == LOAD_A) || (st == LOAD_B);
  assign tmo       = loading && !rx_valid
                     && (tcnt == TW'(TIMEOUT - 1));
  assign size_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));
  assign sq        = IW'(rx_data[3:0]) * IW'(rx_data[3:0]);
  assign idx_last  = (idx == (limit - IW'(1)));
  assign last_byte = (bcnt == BW'(BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:
        if (rx_valid && rx_data == SYNC) nxt = SIZE;
      SIZE:
        if (rx_valid)  nxt = size_ok ? LOAD_A : ERR;
        else if (tmo)  nxt = ERR;
      LOAD_A:
        if (rx_valid) begin
          if (idx_last) nxt = LOAD_B;
        end else if (tmo) nxt = ERR;
      LOAD_B:
        if (rx_valid) begin
          if (idx_last) nxt = COMPUTE;
        end else if (tmo) nxt = ERR;
      // done is only trusted once mult_start has been issued
      COMPUTE:
        if (in_comp && mult_done) nxt = SEND;
      SEND:
        if (ph == PH_TX && tx_ready && last_byte && idx_last)
          nxt = IDLE;
      ERR:
        if (tx_ready) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    rd_addr  = '0;
    if (st == ERR) begin
      tx_valid = 1'b1;
      tx_data  = ERR_CODE;
    end else if (st == SEND) begin
      rd_addr = idx[AW-1:0];
      if (ph == PH_TX) begin
        tx_valid = 1'b1;
        tx_data  = shreg[RES_W-1 -: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_sel      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'd0;
      mult_start  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      matrix_size <= 4'd0;
      idx         <= '0;
      limit       <= '0;
      tcnt        <= '0;
      shreg       <= '0;
      bcnt        <= '0;
      ph          <= PH_ADDR;
      in_comp     <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      mult_start <= 1'b0;
      done       <= 1'b0;
      err        <= (nxt == ERR) && (st != ERR);
      in_comp    <= (st == COMPUTE);
      if (!loading || rx_valid) tcnt <= '0;
      else                      tcnt <= tcnt + TW'(1);
      case (st)
        SIZE:
          if (rx_valid && size_ok) begin
            matrix_size <= rx_data[3:0];
            limit       <= sq;
            idx         <= '0;
          end
        LOAD_A, LOAD_B:
          if (rx_valid) begin
            wr_en   <= 1'b1;
            wr_sel  <= (st == LOAD_B);
            wr_addr <= idx[AW-1:0];
            wr_data <= rx_data;
            idx     <= idx_last ? '0 : idx + IW'(1);
          end
        COMPUTE: begin
          if (!in_comp) mult_start <= 1'b1;
          idx  <= '0;
          bcnt <= '0;
          ph   <= PH_ADDR;
        end
        SEND:
          case (ph)
            PH_ADDR:  ph <= PH_LATCH;
            PH_LATCH: begin
              shreg <= rd_data;
              bcnt  <= '0;
              ph    <= PH_TX;
            end
            PH_TX:
              if (tx_ready) begin
                shreg <= shreg << 8;
                if (last_byte) begin
                  bcnt <= '0;
                  ph   <= PH_ADDR;
                  if (idx_last) begin
                    done <= 1'b1;
                    idx  <= '0;
                  end else begin
                    idx <= idx + IW'(1);
                  end
                end else begin
                  bcnt <= bcnt + BW'(1);
                end
              end
            default: ph <= PH_ADDR;
          endcase
        default: ;
      endcase
    end
  end

endmodule
